exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have reset synchronous, active-high; clock clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 WPC_M  input  32  PC of the instruction in the M stage.
REQ-005 BD_M  input  1  M-stage instruction sits in a branch delay slot.
REQ-006 ExcCode_M  input  5  M-stage exception code; 0 means no exception.
REQ-007 HWInt  input  6  external hardware interrupt lines.
REQ-008 we_cp0  input  1  mtc0 write strobe from the M stage.
REQ-009 addr_cp0  input  5  CP0 register number for mtc0/mfc0.
REQ-010 wdata_cp0  input  32  mtc0 write data.
REQ-011 eret_M  input  1  eret in the M stage.
REQ-012 rdata_cp0  output  32  mfc0 read data.
REQ-013 Req  output  1  flush of all pipeline registers with redirect to 0x0000_4180.
REQ-014 EPC_out  output  32  eret return target.

Function
REQ-015 SHALL hold SR (reg 12: IM=[15:10], EXL=[1], IE=[0]), Cause (reg 13: BD=[31], IP=[15:10], ExcCode=[6:2]) and EPC (reg 14); all other bits SHALL read 0.
REQ-016 IntReq SHALL be |(HWInt & SR.IM) & SR.IE & ~SR.EXL, computed combinationally.
REQ-017 ExcReq SHALL be (ExcCode_M != 0) & ~SR.EXL, computed combinationally.
REQ-018 Req SHALL be IntReq | ExcReq, combinational, with zero-cycle latency.
REQ-019 On a clock edge with Req=1: EXL<=1; Cause.BD<=BD_M; Cause.ExcCode<=0 if IntReq, else ExcCode_M (interrupt wins over exception); EPC<={(BD_M ? WPC_M-4 : WPC_M)[31:2],2'b00}.
REQ-020 Cause.IP SHALL load HWInt on every non-reset edge, independent of Req.
REQ-021 An mtc0 to reg 12 SHALL update only IM, EXL and IE.
REQ-022 An mtc0 to reg 14 SHALL store wdata_cp0 with bits [1:0] forced to 0.
REQ-023 Cause SHALL be read-only to mtc0; writes to reg 13 and to unlisted registers SHALL be ignored.
REQ-024 When Req=1, a same-cycle mtc0 and a same-cycle eret SHALL be ignored.
REQ-025 eret_M=1 with Req=0 SHALL clear EXL on the next edge.
REQ-026 EPC_out SHALL equal EPC, except that it SHALL forward {wdata_cp0[31:2],2'b00} when we_cp0=1 and addr_cp0=14 in the same cycle.
REQ-027 rdata_cp0 SHALL be a combinational read of addr_cp0 with no bypass, returning 0 for unlisted registers.
REQ-028 While EXL=1, no new interrupt or exception SHALL be taken, and EPC and Cause.ExcCode SHALL hold.

Reset
REQ-029 On reset=1 at an edge, SR, Cause and EPC SHALL clear to 0.
REQ-030 Req SHALL be forced to 0 while reset=1.
REQ-031 After reset, rdata_cp0 and EPC_out SHALL read 0.
REQ-032 Reset SHALL take priority over Req, mtc0 and eret.

Configuration
REQ-033 The macro EXC_CTRL_PRID_EN, when defined, SHALL add a read-only PRId register at addr 15 returning the constant 32'h4D49_5053.
REQ-034 Without EXC_CTRL_PRID_EN, reg 15 SHALL read 0 and all other behaviour SHALL be identical.

Verification
REQ-035 Reset, then read regs 12/13/14 -> all return 0; Req=0.
REQ-036 SR=0x0000_0401, HWInt=6'b000001, WPC_M=0x3010, BD_M=0 -> Req=1 in the same cycle; next cycle EPC=0x3010, ExcCode=0, EXL=1, Req=0.
REQ-037 ExcCode_M=4, BD_M=1, WPC_M=0x3024 -> Req=1; next cycle EPC=0x3020, Cause=0x8000_0010.
REQ-038 Same cycle: ExcCode_M=10 and enabled interrupt pending -> Cause.ExcCode=0 (interrupt wins).
REQ-039 Same cycle: mtc0 EPC=0x3107 and eret -> EPC_out=0x3104 in that cycle; next cycle EXL=0.
REQ-040 Same cycle: ExcCode_M=12 and mtc0 SR=0 -> the SR write is dropped; SR.EXL=1 next cycle.

Source files
------------

// File: rtl/exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC, interrupt/exception request, mtc0/mfc0, eret.
// Define EXC_CTRL_PRID_EN to add the read-only PRId register at CP0 address 15.
module exc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] WPC_M,
    input  logic        BD_M,
    input  logic [4:0]  ExcCode_M,
    input  logic [5:0]  HWInt,
    input  logic        we_cp0,
    input  logic [4:0]  addr_cp0,
    input  logic [31:0] wdata_cp0,
    input  logic        eret_M,
    output logic [31:0] rdata_cp0,
    output logic        Req,
    output logic [31:0] EPC_out
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic        int_req;
    logic        exc_req;
    logic        wr_sr;
    logic        wr_epc;
    logic [31:0] victim_pc;

    assign int_req   = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req   = (ExcCode_M != 5'd0) & ~sr_exl;
    assign Req       = ~reset & (int_req | exc_req);
    assign wr_sr     = we_cp0 && (addr_cp0 == ADDR_SR);
    assign wr_epc    = we_cp0 && (addr_cp0 == ADDR_EPC);
    // A delay-slot instruction returns to its branch, one word earlier.
    assign victim_pc = BD_M ? (WPC_M - 32'd4) : WPC_M;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= HWInt;
            if (Req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= BD_M;
                cause_exc <= int_req ? 5'd0 : ExcCode_M;
                epc       <= victim_pc & 32'hFFFF_FFFC;
            end else begin
                if (wr_sr) begin
                    sr_im  <= wdata_cp0[15:10];
                    sr_exl <= wdata_cp0[1];
                    sr_ie  <= wdata_cp0[0];
                end
                if (wr_epc) begin
                    epc <= wdata_cp0 & 32'hFFFF_FFFC;
                end
                // eret is placed last so it wins over a same-cycle SR write to EXL.
                if (eret_M) begin
                    sr_exl <= 1'b0;
                end
            end
        end
    end

    assign EPC_out = wr_epc ? (wdata_cp0 & 32'hFFFF_FFFC) : epc;

    always_comb begin
        rdata_cp0 = 32'd0;
        case (addr_cp0)
            ADDR_SR:    rdata_cp0 = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
            ADDR_CAUSE: rdata_cp0 = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
            ADDR_EPC:   rdata_cp0 = epc;
`ifdef EXC_CTRL_PRID_EN
            ADDR_PRID:  rdata_cp0 = 32'h4D49_5053;
`else
            ADDR_PRID:  rdata_cp0 = 32'd0;
`endif
            default:    rdata_cp0 = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: directed scenarios followed by random traffic,
// checked against a word-level CP0 model.
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] WPC_M;
    logic        BD_M;
    logic [4:0]  ExcCode_M;
    logic [5:0]  HWInt;
    logic        we_cp0;
    logic [4:0]  addr_cp0;
    logic [31:0] wdata_cp0;
    logic        eret_M;
    logic [31:0] rdata_cp0;
    logic        Req;
    logic [31:0] EPC_out;

    exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .WPC_M     (WPC_M),
        .BD_M      (BD_M),
        .ExcCode_M (ExcCode_M),
        .HWInt     (HWInt),
        .we_cp0    (we_cp0),
        .addr_cp0  (addr_cp0),
        .wdata_cp0 (wdata_cp0),
        .eret_M    (eret_M),
        .rdata_cp0 (rdata_cp0),
        .Req       (Req),
        .EPC_out   (EPC_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic        req;
        logic [31:0] epc_out;
        logic [31:0] rdata;
    } expect_t;

    expect_t     sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cycle_no = 0;

    // Architectural CP0 state as whole 32-bit words.
    logic [31:0] m_sr    = 32'd0;
    logic [31:0] m_cause = 32'd0;
    logic [31:0] m_epc   = 32'd0;

    localparam logic [31:0] SR_WRITABLE = 32'h0000_FC03;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
`ifdef EXC_CTRL_PRID_EN
            5'd15:   return 32'h4D49_5053;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] cyc,
                               input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, actual, required);
        end
    endtask

    // Drive one cycle, queue the expected outputs, advance the model past the edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] pc, input logic bd,
                                 input logic [4:0] exc, input logic [5:0] hw, input logic we,
                                 input logic [4:0] addr, input logic [31:0] wd, input logic eret);
        expect_t e;
        logic    int_req;
        logic    exc_req;
        logic    req;
        logic    exl;
        reset     = rst;
        WPC_M     = pc;
        BD_M      = bd;
        ExcCode_M = exc;
        HWInt     = hw;
        we_cp0    = we;
        addr_cp0  = addr;
        wdata_cp0 = wd;
        eret_M    = eret;

        exl     = m_sr[1];
        int_req = ((hw & m_sr[15:10]) != 6'd0) && m_sr[0] && !exl;
        exc_req = (exc != 5'd0) && !exl;
        req     = !rst && (int_req || exc_req);

        e.cyc     = cycle_no;
        e.req     = req;
        e.epc_out = (we && addr == 5'd14) ? {wd[31:2], 2'b00} : m_epc;
        e.rdata   = model_read(addr);
        sb_q.push_back(e);

        if (rst) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else begin
            m_cause[15:10] = hw;
            if (req) begin
                m_sr[1]       = 1'b1;
                m_cause[31]   = bd;
                m_cause[6:2]  = int_req ? 5'd0 : exc;
                m_epc         = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
            end else begin
                if (we && addr == 5'd12) m_sr  = wd & SR_WRITABLE;
                if (we && addr == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
                if (eret) m_sr[1] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic idleRead(input logic [4:0] addr);
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0, addr, 32'd0, 1'b0);
    endtask

    // Monitor: outputs are combinational and present every cycle.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("Req",       e.cyc, {31'd0, Req}, {31'd0, e.req});
                checkOutput("EPC_out",   e.cyc, EPC_out,      e.epc_out);
                checkOutput("rdata_cp0", e.cyc, rdata_cp0,    e.rdata);
            end
        end
    end

    initial begin
        logic [4:0]  addr;
        logic        we;
        logic        eret;
        logic [4:0]  exc;
        int          drain;
        reset = 1'b1; WPC_M = 32'd0; BD_M = 1'b0; ExcCode_M = 5'd0; HWInt = 6'd0;
        we_cp0 = 1'b0; addr_cp0 = 5'd0; wdata_cp0 = 32'd0; eret_M = 1'b0;
        @(posedge clk);
        #1;

        // Reset state and Req suppressed while reset is high, even with a pending exception.
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 5'd4, 6'h3F, 1'b0, 5'd12, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0, 5'd14, 32'd0, 1'b0);
        idleRead(5'd12);
        idleRead(5'd13);
        idleRead(5'd14);
        idleRead(5'd15);

        // Enabled interrupt.
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
        applyStimulus(1'b0, 32'h0000_3010, 1'b0, 5'd0, 6'b000001, 1'b0, 5'd14, 32'd0, 1'b0);
        idleRead(5'd14);
        idleRead(5'd12);
        idleRead(5'd13);
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);

        // Exception in a delay slot.
        applyStimulus(1'b0, 32'h0000_3024, 1'b1, 5'd4, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
        idleRead(5'd13);
        idleRead(5'd14);
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);

        // Interrupt and exception together: interrupt code wins.
        applyStimulus(1'b0, 32'h0000_3040, 1'b0, 5'd10, 6'b000001, 1'b0, 5'd13, 32'd0, 1'b0);
        idleRead(5'd13);
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b0, 5'd12, 32'd0, 1'b1);

        // mtc0 EPC forwarded during eret.
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b1, 5'd14, 32'h0000_3107, 1'b1);
        idleRead(5'd12);
        idleRead(5'd14);

        // SR write dropped when an exception is taken in the same cycle.
        applyStimulus(1'b0, 32'h0000_3050, 1'b0, 5'd12, 6'd0, 1'b1, 5'd12, 32'd0, 1'b0);
        idleRead(5'd12);
        idleRead(5'd13);

        // Cause is read-only.
        applyStimulus(1'b0, 32'h0000_3000, 1'b0, 5'd0, 6'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0);
        idleRead(5'd13);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0:       addr = 5'd12;
                1:       addr = 5'd13;
                2:       addr = 5'd14;
                3:       addr = 5'd15;
                default: addr = 5'($urandom);
            endcase
            we   = ($urandom_range(0, 9) < 3);
            eret = ($urandom_range(0, 9) < 2);
            if (eret && addr == 5'd12) we = 1'b0;
            exc  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            applyStimulus(($urandom_range(0, 49) == 0), $urandom, 1'($urandom),
                          exc, 6'($urandom), we, addr, $urandom, eret);
        end

        drain = 0;
        while (sb_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #1;
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
